// File: rtl/crt_phosphor_blur.sv
// CRT phosphor emulation: 3-tap horizontal blur combined with line-to-line
// persistence decay, on a 3-clock pipeline with sync pass-through.
module crt_phosphor_blur #(
  parameter int H_ACTIVE    = 1024,
  parameter int DECAY_SHIFT = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] pixel_in,
  input  logic       de_in,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       blur_en,
  input  logic [7:0] line_tap,
  output logic [7:0] line_wr,
  output logic [7:0] pixel_out,
  output logic       de_out,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       line_len_err
);

  localparam logic [10:0] LINE_LEN = 11'(H_ACTIVE);

  logic [7:0]  pix1_r, cen2_r, lft2_r, tap2_r;
  logic        de1_r, hs1_r, vs1_r;
  logic        de2_r, del2_r, hs2_r, vs2_r;
  logic        first_line_r;
  logic [10:0] col_cnt_r;

  logic        de_fall_in_s, de_fall2_s, vs_rise2_s;
  logic [7:0]  left_s, right_s, h_s, d_s, max_s, out_s, wr_s;
  logic [9:0]  sum_s;

  assign de_fall_in_s = de1_r & ~de_in;
  // Frame/line markers are taken from stage-1 registers so first_line moves with stage 2.
  assign de_fall2_s   = de2_r & ~de1_r;
  assign vs_rise2_s   = vs1_r & ~vs2_r;

  // Stage 1 and stage 2 pipeline registers, plus the tap gated by first_line.
  always_ff @(posedge clock) begin
    if (reset) begin
      pix1_r <= 8'd0;
      de1_r  <= 1'b0;
      hs1_r  <= 1'b0;
      vs1_r  <= 1'b0;
      cen2_r <= 8'd0;
      lft2_r <= 8'd0;
      tap2_r <= 8'd0;
      de2_r  <= 1'b0;
      del2_r <= 1'b0;
      hs2_r  <= 1'b0;
      vs2_r  <= 1'b0;
    end else begin
      pix1_r <= pixel_in;
      de1_r  <= de_in;
      hs1_r  <= hsync_in;
      vs1_r  <= vsync_in;
      cen2_r <= pix1_r;
      lft2_r <= cen2_r;
      tap2_r <= first_line_r ? 8'd0 : line_tap;
      de2_r  <= de1_r;
      del2_r <= de2_r;
      hs2_r  <= hs1_r;
      vs2_r  <= vs1_r;
    end
  end

  // Frame-start tracking; a vsync edge beats a coincident end of line.
  always_ff @(posedge clock) begin
    if (reset) begin
      first_line_r <= 1'b1;
    end else if (vs_rise2_s) begin
      first_line_r <= 1'b1;
    end else if (de_fall2_s) begin
      first_line_r <= 1'b0;
    end else begin
      first_line_r <= first_line_r;
    end
  end

  // Active-run length measurement with a sticky error flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      col_cnt_r    <= 11'd0;
      line_len_err <= 1'b0;
    end else begin
      if (de_in) begin
        col_cnt_r <= (col_cnt_r == 11'd2047) ? col_cnt_r : col_cnt_r + 11'd1;
      end else begin
        col_cnt_r <= 11'd0;
      end
      if (de_fall_in_s && (col_cnt_r != LINE_LEN)) begin
        line_len_err <= 1'b1;
      end else begin
        line_len_err <= line_len_err;
      end
    end
  end

  // Stage 3 datapath: edge-replicated window, decay, and bypass selection.
  always_comb begin
    left_s  = del2_r ? lft2_r : cen2_r;
    right_s = de1_r ? pix1_r : cen2_r;
    sum_s   = {2'b00, left_s} + {1'b0, cen2_r, 1'b0} + {2'b00, right_s};
    h_s     = sum_s[9:2];
    d_s     = tap2_r - (tap2_r >> DECAY_SHIFT);
    max_s   = (h_s > d_s) ? h_s : d_s;
    out_s   = 8'd0;
    wr_s    = 8'd0;
    if (!de2_r) begin
      out_s = 8'd0;
      wr_s  = 8'd0;
    end else if (blur_en) begin
      out_s = max_s;
      wr_s  = max_s;
    end else begin
      out_s = cen2_r;
      wr_s  = 8'd0;
    end
  end

  // Stage 3 output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      pixel_out <= 8'd0;
      line_wr   <= 8'd0;
      de_out    <= 1'b0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      pixel_out <= out_s;
      line_wr   <= wr_s;
      de_out    <= de2_r;
      hsync_out <= hs2_r;
      vsync_out <= vs2_r;
    end
  end

endmodule

// File: tb/tb_crt_phosphor_blur.sv
// Directed line-by-line stimulus with randomized pixels/taps, checked against
// a per-column arithmetic model of the blur/decay rules.
module tb_crt_phosphor_blur;

  localparam int H     = 1024;
  localparam int DS    = 2;
  localparam int BLANK = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] pixel_in;
  logic       de_in, hsync_in, vsync_in, blur_en;
  logic [7:0] line_tap;
  logic [7:0] line_wr, pixel_out;
  logic       de_out, hsync_out, vsync_out, line_len_err;

  always #5 clock = ~clock;

  crt_phosphor_blur #(.H_ACTIVE(H), .DECAY_SHIFT(DS)) dut (
    .clock(clock), .reset(reset), .pixel_in(pixel_in), .de_in(de_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .blur_en(blur_en),
    .line_tap(line_tap), .line_wr(line_wr), .pixel_out(pixel_out),
    .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .line_len_err(line_len_err)
  );

  typedef struct packed {
    logic [7:0] pix;
    logic [7:0] wr;
    logic       de;
    logic       hs;
    logic       vs;
  } rec_t;

  rec_t       exp_q[$];
  logic [7:0] pix_a [0:2047];
  logic [7:0] tap_a [0:2047];
  int         checks = 0;
  int         errors = 0;
  logic       err_model;
  logic       fl_model;

  // Expected output of one active column from the line's inputs.
  function automatic logic [7:0] col_exp(input int n, input int k, input logic fl, input logic bl);
    int l, c, r, h, t, d;
    c = int'(pix_a[k]);
    l = (k > 0) ? int'(pix_a[k-1]) : c;
    r = (k < n - 1) ? int'(pix_a[k+1]) : c;
    h = (l + 2 * c + r) / 4;
    t = fl ? 0 : int'(tap_a[k]);
    d = t - t / (2 ** DS);
    return bl ? 8'((h > d) ? h : d) : 8'(c);
  endfunction

  task automatic check_out(input rec_t r, input string tag);
    checks++;
    assert ({pixel_out, line_wr} === {r.pix, r.wr}) else begin
      errors++;
      $error("FAIL %s_data observed pix=%0d wr=%0d expected pix=%0d wr=%0d", tag, pixel_out, line_wr, r.pix, r.wr);
    end
    checks++;
    assert ({de_out, hsync_out, vsync_out} === {r.de, r.hs, r.vs}) else begin
      errors++;
      $error("FAIL %s_ctl observed de/hs/vs=%b%b%b expected %b%b%b", tag, de_out, hsync_out, vsync_out, r.de, r.hs, r.vs);
    end
  endtask

  task automatic check_err(input logic e, input string tag);
    checks++;
    assert (line_len_err === e) else begin
      errors++;
      $error("FAIL %s_len_err observed %b expected %b", tag, line_len_err, e);
    end
  endtask

  task automatic drive_cycle(input logic [7:0] px, input logic bl, input logic [7:0] tp,
                             input rec_t e, input logic err_e);
    pixel_in = px;
    de_in    = e.de;
    hsync_in = e.hs;
    vsync_in = e.vs;
    blur_en  = bl;
    line_tap = tp;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    if (exp_q.size() == 3) check_out(exp_q.pop_front(), "stream");
    check_err(err_e, "stream");
  endtask

  task automatic restart_pipe();
    rec_t z;
    z = '0;
    reset    = 1'b0;
    pixel_in = 8'd0;
    de_in    = 1'b0;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    exp_q.delete();
    exp_q.push_back(z);
    exp_q.push_back(z);
    err_model = 1'b0;
    fl_model  = 1'b1;
  endtask

  // One line of n active pixels plus blanking; blur_en switches from b0 to b1 at cycle tcol.
  task automatic run_line(input int n, input int vs_pos, input int tcol,
                          input logic b0, input logic b1, input int abort_at);
    rec_t       e;
    rec_t       z;
    logic [7:0] px, tp;
    logic       bad, bl_px, aborted;
    bad     = (n != H);
    aborted = 1'b0;
    z       = '0;
    for (int j = 0; j < n + BLANK; j++) begin
      if (j == abort_at) begin
        reset    = 1'b1;
        pixel_in = pix_a[j];
        de_in    = 1'b1;
        @(posedge clock);
        #1;
        check_out(z, "mid_reset");
        check_err(1'b0, "mid_reset");
        restart_pipe();
        aborted = 1'b1;
        break;
      end
      e    = '0;
      px   = (j < n) ? pix_a[j] : 8'($urandom_range(255, 0));
      tp   = (j >= 1 && j <= n) ? tap_a[j-1] : 8'($urandom_range(255, 0));
      e.de = (j < n);
      e.hs = (j >= n + 2) && (j < n + 5);
      e.vs = (vs_pos >= 0) && (j == n + vs_pos);
      if (j < n) begin
        bl_px = ((j + 2) < tcol) ? b0 : b1;
        e.pix = col_exp(n, j, fl_model, bl_px);
        e.wr  = bl_px ? e.pix : 8'd0;
      end
      drive_cycle(px, (j < tcol) ? b0 : b1, tp, e, err_model | (bad & (j >= n)));
    end
    if (!aborted) begin
      err_model = err_model | bad;
      fl_model  = (vs_pos >= 0);
    end
  endtask

  initial begin
    rec_t z;
    z        = '0;
    reset    = 1'b1;
    pixel_in = 8'd0;
    de_in    = 1'b0;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    blur_en  = 1'b0;
    line_tap = 8'd0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      check_out(z, "reset");
      check_err(1'b0, "reset");
    end
    restart_pipe();

    // Flat field, vsync in blanking keeps the next line as first line.
    for (int k = 0; k < H; k++) begin pix_a[k] = 8'd100; tap_a[k] = 8'd0; end
    run_line(H, 3, 0, 1'b1, 1'b1, -1);

    // Single bright pixel on a first line; random taps must be ignored.
    for (int k = 0; k < H; k++) begin pix_a[k] = 8'd0; tap_a[k] = 8'($urandom_range(255, 0)); end
    pix_a[10] = 8'd200;
    run_line(H, -1, 0, 1'b1, 1'b1, -1);

    // Decay over two lines of black.
    for (int k = 0; k < H; k++) begin pix_a[k] = 8'd0; tap_a[k] = 8'd100; end
    run_line(H, -1, 0, 1'b1, 1'b1, -1);
    for (int k = 0; k < H; k++) tap_a[k] = 8'd75;
    run_line(H, -1, 0, 1'b1, 1'b1, -1);

    // Bypass ramp; vsync rises together with de falling.
    for (int k = 0; k < H; k++) begin pix_a[k] = 8'(k); tap_a[k] = 8'($urandom_range(255, 0)); end
    run_line(H, 0, 0, 1'b0, 1'b0, -1);

    // Random content: first line, then blur toggled mid-line both ways.
    for (int l = 0; l < 3; l++) begin
      for (int k = 0; k < H; k++) begin
        pix_a[k] = 8'($urandom_range(255, 0));
        tap_a[k] = 8'($urandom_range(255, 0));
      end
      case (l)
        0:       run_line(H, -1, 0, 1'b1, 1'b1, -1);
        1:       run_line(H, -1, 300, 1'b1, 1'b0, -1);
        default: run_line(H, 5, 600, 1'b0, 1'b1, -1);
      endcase
    end

    // Short run sets the sticky error; very short lines exercise both window edges.
    for (int k = 0; k < H; k++) begin
      pix_a[k] = 8'($urandom_range(255, 0));
      tap_a[k] = 8'($urandom_range(255, 0));
    end
    run_line(H - 1, -1, 0, 1'b1, 1'b1, -1);
    run_line(1, -1, 0, 1'b1, 1'b1, -1);
    run_line(2, -1, 0, 1'b1, 1'b1, -1);
    run_line(5, -1, 0, 1'b1, 1'b1, -1);

    // Reset mid-line, then a line with saturated taps that must not show through.
    run_line(H, -1, 0, 1'b1, 1'b1, 500);
    for (int k = 0; k < H; k++) begin pix_a[k] = 8'($urandom_range(255, 0)); tap_a[k] = 8'd255; end
    run_line(H, -1, 0, 1'b1, 1'b1, -1);
    for (int k = 0; k < H; k++) begin
      pix_a[k] = 8'($urandom_range(127, 0));
      tap_a[k] = 8'($urandom_range(255, 0));
    end
    run_line(H, -1, 0, 1'b1, 1'b1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/crt_phosphor_blur.md
CRT_PHOSPHOR_BLUR -- requirements
Module: crt_phosphor_blur

Interface
REQ-001 Parameter H_ACTIVE, default 1024, active pixels per line.
REQ-002 Parameter DECAY_SHIFT, default 2, right-shift amount used for line-to-line phosphor decay.
REQ-003 Port clock, input, 1, single clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port reset, input, 1, synchronous, active-high.
REQ-005 Port pixel_in, input, 8, incoming pixel intensity.
REQ-006 Port de_in, input, 1, data enable; pixel_in is valid when high.
REQ-007 Port hsync_in, input, 1, horizontal sync, passed through.
REQ-008 Port vsync_in, input, 1, vertical sync, passed through and used as frame marker.
REQ-009 Port blur_en, input, 1, 1 = blur and decay active, 0 = bypass.
REQ-010 Port line_tap, input, 8, previous-line persisted value from the line shift register taps output.
REQ-011 Port line_wr, output, 8, value fed to the line shift register shiftin.
REQ-012 Port pixel_out, output, 8, blurred intensity.
REQ-013 Ports de_out, hsync_out, vsync_out, output, 1 each, de_in, hsync_in and vsync_in delayed to match pixel_out.
REQ-014 Port line_len_err, output, 1, sticky flag set on any active run whose length is not H_ACTIVE.

Function
REQ-015 Latency SHALL be exactly 3 clocks from pixel_in/de_in/hsync_in/vsync_in to pixel_out/de_out/hsync_out/vsync_out; line_wr SHALL be driven in the same cycle as pixel_out.
REQ-016 The pipeline SHALL be organized as follows: stage 1 registers input pixel, de and syncs; stage 2 forms a 3-pixel horizontal window (left, center, right) plus the registered line_tap; stage 3 computes and registers the outputs.
REQ-017 Window edges: left SHALL equal center when the left sample's de was 0 (first pixel of the line), and right SHALL equal center when the right sample's de is 0 (last pixel of the line).
REQ-018 h = (left + 2*center + right) >> 2, computed at 10-bit width with no overflow; the result SHALL fit in 8 bits.
REQ-019 Decayed previous-line value d = tap - (tap >> DECAY_SHIFT), computed at 8-bit width; d SHALL never underflow.
REQ-020 tap SHALL be the line_tap value sampled alongside the center pixel; the line shift register guarantees column alignment for a 3-clock loop delay.
REQ-021 tap SHALL be forced to 0 while first_line = 1.
REQ-022 The active-pixel output SHALL be pixel_out = max(h, d) when blur_en = 1, and pixel_out = center when blur_en = 0.
REQ-023 line_wr SHALL equal pixel_out when blur_en = 1 and the delayed de = 1; otherwise line_wr SHALL be 0, which clears persistence in bypass mode.
REQ-024 When the delayed de = 0, pixel_out SHALL be 0 and line_wr SHALL be 0.
REQ-025 Column counter (11 bits) SHALL increment on each de_in = 1 cycle, saturate at 2047, and clear on each de_in 1->0 transition.
REQ-026 On each de_in 1->0 transition, if column count != H_ACTIVE then line_len_err SHALL be set to 1; it stays at 1 until reset.
REQ-027 first_line SHALL be set on each vsync_in 0->1 edge and cleared on the first de_in 1->0 edge after it.
REQ-028 The first_line flag SHALL be updated at stage 2 so that it takes effect on the whole line consistently.
REQ-029 If a vsync edge and a de falling edge occur in the same cycle, the vsync edge SHALL win and first_line SHALL end at 1.
REQ-030 A blur_en change mid-line SHALL take effect for pixels entering stage 3 on the following clock; there SHALL be no glitch on de_out or the sync outputs.

Reset
REQ-031 While reset = 1, all pipeline registers, pixel_out, line_wr, de_out, hsync_out, vsync_out, line_len_err and the column counter SHALL be 0, and first_line SHALL be 1.
REQ-032 Reset asserted mid-line SHALL discard in-flight pixels; the first post-reset output SHALL appear 3 clocks after the first post-reset input.
REQ-033 The edge detectors SHALL treat the previous de_in and vsync_in as 0 after reset.

Verification
REQ-034 Flat field: blur_en = 1, line_tap = 0, pixel_in = 100 for 1024 pixels -> pixel_out = 100 for every pixel, including the edges, and line_wr = 100.
REQ-035 Single bright pixel: pixel_in = 200 at column 10, 0 elsewhere, first_line = 1 -> pixel_out is 50, 100, 50 at columns 9, 10, 11 and 0 elsewhere; output begins 3 clocks after the input.
REQ-036 Decay: second line all zeros with line_tap = 100, DECAY_SHIFT = 2 -> pixel_out = 75 for every pixel; a third line with line_tap = 75 -> pixel_out = 57.
REQ-037 Bypass: blur_en = 0, pixel_in ramp 0..255 -> pixel_out equals the ramp delayed 3 clocks, and line_wr = 0 throughout.
REQ-038 Line length: a de run of 1023 pixels -> line_len_err = 1 within 2 clocks of de falling and held until reset; a 1024-pixel run after reset -> line_len_err stays 0.
REQ-039 Reset mid-line: assert reset at column 500 for 1 clock -> all outputs 0 on the next clock and first_line = 1; on the next line line_tap is ignored (a line_tap = 255 input does not appear in pixel_out).
